// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate bus between the VGA timing source and the drawing blocks.
// The master (timing generator) drives sync/coordinates/strobes; the slave supplies pixel enable and scroll control.
interface vga_timing_gen_if;
  logic       pix_ce;
  logic       scroll_en;
  logic [3:0] scroll_step;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       line_tick;
  logic       frame_tick;
  logic [9:0] x_offset;

  modport master (
    input  pix_ce, scroll_en, scroll_step,
    output hsync, vsync, display_on, pix_x, pix_y, line_tick, frame_tick, x_offset
  );

  modport slave (
    output pix_ce, scroll_en, scroll_step,
    input  hsync, vsync, display_on, pix_x, pix_y, line_tick, frame_tick, x_offset
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing source: pixel/line counters, sync decodes and game strobes.
// Optional frame-rate scroll offset register is built only when SCROLL_OFFSET_EN is defined.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga_o
);

  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);

  logic [9:0] pix_x_q, pix_x_d;
  logic [9:0] pix_y_q, pix_y_d;
  logic       frame_tick_s;

  // Counter next-state: pix_y steps and wraps only on the pix_x wrap edge.
  always_comb begin
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    if (vga_o.pix_ce) begin
      if (pix_x_q == H_LAST) begin
        pix_x_d = 10'd0;
        if (pix_y_q == V_LAST) begin
          pix_y_d = 10'd0;
        end else begin
          pix_y_d = pix_y_q + 10'd1;
        end
      end else begin
        pix_x_d = pix_x_q + 10'd1;
      end
    end else begin
      pix_x_d = pix_x_q;
      pix_y_d = pix_y_q;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_x_q <= 10'd0;
      pix_y_q <= 10'd0;
    end else begin
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
    end
  end

  // Decodes are zero-latency so they stay aligned with the coordinates they describe.
  assign frame_tick_s     = vga_o.pix_ce && (pix_x_q == 10'd0) && (pix_y_q == V_VIS);
  assign vga_o.frame_tick = frame_tick_s;
  assign vga_o.line_tick  = vga_o.pix_ce && (pix_x_q == H_VIS);
  assign vga_o.display_on = (pix_x_q < H_VIS) && (pix_y_q < V_VIS);
  assign vga_o.hsync      = ((pix_x_q >= HS_START) && (pix_x_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vga_o.vsync      = ((pix_y_q >= VS_START) && (pix_y_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vga_o.pix_x      = pix_x_q;
  assign vga_o.pix_y      = pix_y_q;

`ifdef SCROLL_OFFSET_EN
  logic [9:0]  x_offset_q, x_offset_d;
  logic [10:0] scroll_sum_s;

  // Offset advances once per frame, kept in 0..H_DISPLAY-1 by a single conditional subtract.
  always_comb begin
    scroll_sum_s = {1'b0, x_offset_q} + {7'd0, vga_o.scroll_step};
    x_offset_d   = x_offset_q;
    if (frame_tick_s && vga_o.scroll_en) begin
      if (scroll_sum_s >= 11'(H_DISPLAY)) begin
        x_offset_d = 10'(scroll_sum_s - 11'(H_DISPLAY));
      end else begin
        x_offset_d = scroll_sum_s[9:0];
      end
    end else begin
      x_offset_d = x_offset_q;
    end
  end

  // Scroll offset register.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_offset_q <= 10'd0;
    end else begin
      x_offset_q <= x_offset_d;
    end
  end

  assign vga_o.x_offset = x_offset_q;
`else
  logic unused_scroll_s;
  assign unused_scroll_s = ^{vga_o.scroll_en, vga_o.scroll_step};
  assign vga_o.x_offset  = 10'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line-level timing, reduced-geometry instance for frame-level behaviour.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if vb ();
  vga_timing_gen_if vs ();

  vga_timing_gen dut_big (
    .clk   (clk),
    .rst   (rst),
    .vga_o (vb)
  );

  // Small geometry: H_TOTAL 32 (hsync 20..25), V_TOTAL 20 (vsync rows 14..15), visible 16x12.
  vga_timing_gen #(
    .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
    .SYNC_POL(1'b0)
  ) dut_small (
    .clk   (clk),
    .rst   (rst),
    .vga_o (vs)
  );

`ifdef SCROLL_OFFSET_EN
  localparam int SCR = 1;
`else
  localparam int SCR = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int seq_err, hs_low, hs_first, lt_cnt, de_cnt, hold_err;
    int ft_cnt, ft_x, ft_y, vs_low, vs_first, k;
    bit found;

    rst = 1'b1;
    vb.pix_ce = 1'b0; vb.scroll_en = 1'b0; vb.scroll_step = 4'd0;
    vs.pix_ce = 1'b0; vs.scroll_en = 1'b0; vs.scroll_step = 4'd0;
    repeat (3) @(negedge clk);

    chk("rst_x", 32'(vb.pix_x), 32'd0);
    chk("rst_y", 32'(vb.pix_y), 32'd0);
    chk("rst_hsync", 32'(vb.hsync), 32'd1);
    chk("rst_vsync", 32'(vb.vsync), 32'd1);
    chk("rst_de", 32'(vb.display_on), 32'd1);
    chk("rst_lt", 32'(vb.line_tick), 32'd0);
    chk("rst_ft", 32'(vb.frame_tick), 32'd0);
    chk("rst_xoff", 32'(vb.x_offset), 32'd0);

    // One full line on the real geometry.
    rst = 1'b0;
    vb.pix_ce = 1'b1;
    seq_err = 0; hs_low = 0; hs_first = -1; lt_cnt = 0; de_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (vb.pix_x !== 10'(i) || vb.pix_y !== 10'd0) seq_err++;
      if (vb.hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = i;
      end
      if (vb.line_tick === 1'b1) lt_cnt++;
      if (vb.display_on === 1'b1) de_cnt++;
      @(negedge clk);
    end
    chk("line_seq_err", 32'(seq_err), 32'd0);
    chk("line_hs_low", 32'(hs_low), 32'd96);
    chk("line_hs_first", 32'(hs_first), 32'd656);
    chk("line_lt_cnt", 32'(lt_cnt), 32'd1);
    chk("line_de_cnt", 32'(de_cnt), 32'd640);
    chk("wrap_x", 32'(vb.pix_x), 32'd0);
    chk("wrap_y", 32'(vb.pix_y), 32'd1);

    // Stall just before hsync.
    repeat (655) @(negedge clk);
    chk("pre_stall_x", 32'(vb.pix_x), 32'd655);
    chk("pre_stall_hs", 32'(vb.hsync), 32'd1);
    vb.pix_ce = 1'b0;
    hold_err = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (vb.pix_x !== 10'd655 || vb.hsync !== 1'b1 || vb.line_tick !== 1'b0) hold_err++;
    end
    chk("stall_hold_err", 32'(hold_err), 32'd0);
    vb.pix_ce = 1'b1;
    @(negedge clk);
    chk("resume_x", 32'(vb.pix_x), 32'd656);
    chk("resume_hs", 32'(vb.hsync), 32'd0);

    // Full frame on the small geometry.
    vs.pix_ce = 1'b1;
    ft_cnt = 0; ft_x = -1; ft_y = -1; lt_cnt = 0; de_cnt = 0;
    vs_low = 0; vs_first = -1; hs_low = 0;
    for (int i = 0; i < 640; i++) begin
      if (vs.frame_tick === 1'b1) begin
        ft_cnt++;
        ft_x = int'(vs.pix_x);
        ft_y = int'(vs.pix_y);
      end
      if (vs.line_tick === 1'b1) lt_cnt++;
      if (vs.display_on === 1'b1) de_cnt++;
      if (vs.hsync === 1'b0) hs_low++;
      if (vs.vsync === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = int'(vs.pix_y);
      end
      @(negedge clk);
    end
    chk("frm_ft_cnt", 32'(ft_cnt), 32'd1);
    chk("frm_ft_x", 32'(ft_x), 32'd0);
    chk("frm_ft_y", 32'(ft_y), 32'd12);
    chk("frm_lt_cnt", 32'(lt_cnt), 32'd20);
    chk("frm_de_cnt", 32'(de_cnt), 32'd192);
    chk("frm_hs_low", 32'(hs_low), 32'd120);
    chk("frm_vs_low", 32'(vs_low), 32'd64);
    chk("frm_vs_row", 32'(vs_first), 32'd14);
    chk("frm_wrap_x", 32'(vs.pix_x), 32'd0);
    chk("frm_wrap_y", 32'(vs.pix_y), 32'd0);

    // Mid-frame reset.
    repeat (170) @(negedge clk);
    chk("mid_x", 32'(vs.pix_x), 32'd10);
    chk("mid_y", 32'(vs.pix_y), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_x", 32'(vs.pix_x), 32'd0);
    chk("mrst_y", 32'(vs.pix_y), 32'd0);
    rst = 1'b0;
    k = 0; found = 1'b0;
    while (!found && k < 2000) begin
      if (vs.frame_tick === 1'b1) begin
        found = 1'b1;
      end else begin
        k++;
        @(negedge clk);
      end
    end
    chk("mrst_ft_found", 32'(found), 32'd1);
    chk("mrst_ft_delay", 32'(k), 32'd384);
    chk("ft_pos_y", 32'(vs.pix_y), 32'd12);

    // Strobes gated by pix_ce, and the scroll step applied on this frame_tick edge.
    vs.pix_ce = 1'b0;
    #1;
    chk("ft_gated", 32'(vs.frame_tick), 32'd0);
    vs.pix_ce = 1'b1;
    #1;
    chk("ft_enabled", 32'(vs.frame_tick), 32'd1);
    vs.scroll_en = 1'b1;
    vs.scroll_step = 4'd5;
    @(negedge clk);
    chk("ft_single", 32'(vs.frame_tick), 32'd0);
    chk("xoff_f1", 32'(vs.x_offset), 32'(SCR * 5));
    repeat (15) @(negedge clk);
    vs.pix_ce = 1'b0;
    #1;
    chk("lt_gated", 32'(vs.line_tick), 32'd0);
    vs.pix_ce = 1'b1;
    #1;
    chk("lt_enabled", 32'(vs.line_tick), 32'd1);

    repeat (640) @(negedge clk);
    chk("xoff_f2", 32'(vs.x_offset), 32'(SCR * 10));
    repeat (640) @(negedge clk);
    chk("xoff_f3", 32'(vs.x_offset), 32'(SCR * 15));
    repeat (640) @(negedge clk);
    chk("xoff_wrap", 32'(vs.x_offset), 32'(SCR * 4));
    vs.scroll_step = 4'd0;
    repeat (640) @(negedge clk);
    chk("xoff_step0", 32'(vs.x_offset), 32'(SCR * 4));
    vs.scroll_en = 1'b0;
    vs.scroll_step = 4'd5;
    repeat (640) @(negedge clk);
    chk("xoff_dis", 32'(vs.x_offset), 32'(SCR * 4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
